// File: rtl/cpu_pkg.sv
// Shared core constants: immediate-extension mode encodings and default widths.
package cpu_pkg;

    localparam logic [1:0] EXT_SIGN   = 2'b00;
    localparam logic [1:0] EXT_ZERO   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute immediate bus: input beat, flush and result beat.
// master = the stage driving beats and consuming results, slave = the extension unit.
interface imm_extend_pipe_if
    import cpu_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = DATA_W,
    parameter int unsigned TAG_W = 5
);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/imm_ext_func.sv
// Combinational immediate extender; also used directly by the single-cycle core path.
module imm_ext_func
    import cpu_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = DATA_W
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0] sext;

    // Select the extension; BRANCH drops the top two bits of the sign-extended value.
    always_comb begin
        sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        result = sext;
        case (mode)
            EXT_SIGN:   result = sext;
            EXT_ZERO:   result = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_UPPER:  result = {imm, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: result = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready backpressure, flush and a sideband tag.
module imm_extend_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned IN_W   = IMM_W,
    parameter int unsigned OUT_W  = DATA_W,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5
) (
    input logic               clk,
    input logic               rst_n,
    imm_extend_pipe_if.slave  bus
);

    if (IN_W < 2 || OUT_W < IN_W + 2 || STAGES < 1 || STAGES > 3) begin : g_param_check
        $error("imm_extend_pipe: illegal IN_W/OUT_W/STAGES combination");
    end

    logic [OUT_W-1:0]  ext_data;
    logic [STAGES-1:0] advance;

    logic             valid_q [STAGES];
    logic [OUT_W-1:0] data_q  [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];

    logic             src_valid [STAGES];
    logic [OUT_W-1:0] src_data  [STAGES];
    logic [TAG_W-1:0] src_tag   [STAGES];

    imm_ext_func #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .imm    (bus.in_imm),
        .mode   (bus.in_mode),
        .result (ext_data)
    );

    // A stage may load when it is empty or its contents move on; chained back from the output.
    always_comb begin
        advance = '0;
        advance[STAGES-1] = !valid_q[STAGES-1] || bus.out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            advance[k] = !valid_q[k] || advance[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            // While stage 0 may load and flush is low, in_ready is high, so in_valid is the transfer.
            assign src_valid[k] = bus.in_valid;
            assign src_data[k]  = ext_data;
            assign src_tag[k]   = bus.in_tag;
        end else begin : g_src
            assign src_valid[k] = valid_q[k-1];
            assign src_data[k]  = data_q[k-1];
            assign src_tag[k]   = tag_q[k-1];
        end

        // Stage register: flush drops valids only; payload loads only on an advance with a beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                tag_q[k]   <= '0;
            end else if (bus.flush) begin
                valid_q[k] <= 1'b0;
            end else if (advance[k]) begin
                valid_q[k] <= src_valid[k];
                if (src_valid[k]) begin
                    data_q[k] <= src_data[k];
                    tag_q[k]  <= src_tag[k];
                end
            end
        end
    end

    assign bus.in_ready  = !bus.flush && advance[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: directed and random beats against a queue-based reference model.
module tb_imm_extend_pipe;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus1 ();
    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus2 ();
    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus3 ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) bus8 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1), .TAG_W(5))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2), .TAG_W(5))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3), .TAG_W(5))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .STAGES(1), .TAG_W(5))
        dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // Shared stimulus routed to the selected 16->32 DUT; the others idle and drain.
    int          sel = 1;
    logic        in_valid = 1'b0;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    assign bus1.in_valid  = (sel == 1) && in_valid;
    assign bus1.in_imm    = in_imm;
    assign bus1.in_mode   = in_mode;
    assign bus1.in_tag    = in_tag;
    assign bus1.flush     = (sel == 1) && flush;
    assign bus1.out_ready = (sel == 1) ? out_ready : 1'b1;
    assign bus2.in_valid  = (sel == 2) && in_valid;
    assign bus2.in_imm    = in_imm;
    assign bus2.in_mode   = in_mode;
    assign bus2.in_tag    = in_tag;
    assign bus2.flush     = (sel == 2) && flush;
    assign bus2.out_ready = (sel == 2) ? out_ready : 1'b1;
    assign bus3.in_valid  = (sel == 3) && in_valid;
    assign bus3.in_imm    = in_imm;
    assign bus3.in_mode   = in_mode;
    assign bus3.in_tag    = in_tag;
    assign bus3.flush     = (sel == 3) && flush;
    assign bus3.out_ready = (sel == 3) ? out_ready : 1'b1;

    always_comb begin
        in_ready  = bus1.in_ready;
        out_valid = bus1.out_valid;
        out_data  = bus1.out_data;
        out_tag   = bus1.out_tag;
        case (sel)
            2: begin
                in_ready  = bus2.in_ready;
                out_valid = bus2.out_valid;
                out_data  = bus2.out_data;
                out_tag   = bus2.out_tag;
            end
            3: begin
                in_ready  = bus3.in_ready;
                out_valid = bus3.out_valid;
                out_data  = bus3.out_data;
                out_tag   = bus3.out_tag;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          hold = 1'b0;
    logic [31:0] hold_data;
    logic [4:0]  hold_tag;

    logic [15:0] dir_imm [4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
    logic [31:0] dir_exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC};
    logic [7:0]  imm8    [4] = '{8'h80, 8'hA5, 8'h40, 8'h80};
    logic [1:0]  mode8   [4] = '{EXT_SIGN, EXT_UPPER, EXT_BRANCH, EXT_ZERO};
    logic [15:0] exp8    [4] = '{16'hFF80, 16'hA500, 16'h0100, 16'h0080};

    // Reference: interpret the field as a signed/unsigned number and scale it arithmetically.
    function automatic logic [31:0] ref_ext(input logic [31:0] imm, input int mode,
                                            input int in_w, input int out_w);
        longint v;
        longint span;
        v    = longint'(imm);
        span = longint'(1) << out_w;
        if ((mode == 0 || mode == 3) && imm[in_w-1]) v = v - (longint'(1) << in_w);
        if (mode == 2) v = v * (longint'(1) << (out_w - in_w));
        if (mode == 3) v = v * 4;
        v = v % span;
        if (v < 0) v = v + span;
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the selected DUT: score handshakes, then advance past the edge.
    task automatic cycle(input bit lat_chk);
        beat_t e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(sel));
            end
        end
        if (flush) begin
            chk("flush_in_ready", 64'(in_ready), 64'(0));
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            e.data = ref_ext(32'(in_imm), int'(in_mode), 16, 32);
            e.tag  = in_tag;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        hold      = out_valid && !out_ready && !flush;
        hold_data = out_data;
        hold_tag  = out_tag;
        @(posedge clk);
        #1;
        cyc++;
        if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(out_data), 64'(hold_data));
            chk("hold_tag", 64'(out_tag), 64'(hold_tag));
        end
    endtask

    task automatic drain(input bit lat_chk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) cycle(lat_chk);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic rand_run(input int n, input int p_ready, input int p_flush);
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 99) < p_ready);
            flush     = ($urandom_range(0, 99) < p_flush);
            cycle(1'b0);
        end
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic [15:0] e8;

        bus8.in_valid  = 1'b0;
        bus8.in_imm    = '0;
        bus8.in_mode   = '0;
        bus8.in_tag    = '0;
        bus8.flush     = 1'b0;
        bus8.out_ready = 1'b1;

        // Reset state on every 16->32 configuration
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_out_data", 64'(out_data), 64'(0));
            chk("rst_out_tag", 64'(out_tag), 64'(0));
        end
        rst_n = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            chk("rst_in_ready", 64'(in_ready), 64'(1));
        end

        // STAGES=1: four back-to-back directed beats, one cycle latency
        sel = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_imm   = dir_imm[i];
            in_mode  = 2'(i);
            in_tag   = 5'(i + 1);
            cycle(1'b1);
            chk($sformatf("dir16_%0d", i), 64'(out_data), 64'(dir_exp[i]));
        end
        drain(1'b1);
        rand_run(40, 80, 0);
        drain(1'b0);

        // STAGES=3: ten-beat stream, 3-cycle latency, 1 beat per cycle
        sel = 3;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = 5'(i);
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'(1));
            cycle(1'b1);
        end
        drain(1'b1);

        // STAGES=2: fill with out_ready low, hold, then release
        sel = 2;
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'(16'h1111 * (acc + 1));
            in_mode  = 2'(acc);
            in_tag   = 5'(acc + 20);
            #1;
            if (in_ready) acc++;
            cycle(1'b0);
        end
        chk("fill_accepted", 64'(acc), 64'(2));
        #1;
        chk("fill_in_ready", 64'(in_ready), 64'(0));
        drain(1'b0);
        rand_run(60, 50, 0);
        drain(1'b0);

        // STAGES=3: flush with three beats in flight
        sel = 3;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = 5'(i + 10);
            cycle(1'b0);
        end
        in_tag = 5'd31;
        flush  = 1'b1;
        cycle(1'b0);
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        in_tag = 5'd7;
        cycle(1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("post_flush_empty", 64'(exp_q.size()), 64'(0));
        rand_run(80, 60, 5);
        drain(1'b0);

        // STAGES=3: asynchronous reset between edges with a full pipe
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = 5'(i + 1);
            cycle(1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'(0));
        chk("async_out_data", 64'(out_data), 64'(0));
        chk("async_out_tag", 64'(out_tag), 64'(0));
        exp_q.delete();
        hold = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            chk("post_rst_no_stale", 64'(out_valid), 64'(0));
        end

        // IN_W=8, OUT_W=16: directed then random, continuous stream
        for (int i = 0; i < 24; i++) begin
            bus8.in_valid = 1'b1;
            if (i < 4) begin
                bus8.in_imm  = imm8[i];
                bus8.in_mode = mode8[i];
                e8 = exp8[i];
            end else begin
                bus8.in_imm  = 8'($urandom);
                bus8.in_mode = 2'($urandom);
                e8 = 16'(ref_ext(32'(bus8.in_imm), int'(bus8.in_mode), 8, 16));
            end
            bus8.in_tag = 5'(i);
            @(posedge clk);
            #1;
            chk("w8_out_valid", 64'(bus8.out_valid), 64'(1));
            chk($sformatf("w8_data_%0d", i), 64'(bus8.out_data), 64'(e8));
            chk("w8_tag", 64'(bus8.out_tag), 64'(i));
        end
        bus8.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised immediate-extension unit for the MIPS core's decode path. It replaces the fixed 16-to-32 sign extender.
- Supports four extension modes: sign, zero, upper/LUI and branch-offset.
- Widths are configurable.
- Adds a valid/ready pipelined datapath of configurable depth, with backpressure and flush, so it can sit between the decode and execute stages.
- A sideband tag (e.g. destination register index) travels with each result.

Parameters:
IN_W, 16, immediate field width; legal 2..OUT_W-2
OUT_W, 32, extended result width
STAGES, 1, pipeline register stages; legal 1..3
TAG_W, 5, sideband tag width carried alongside the data

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_imm  input  IN_W  raw immediate field
in_mode  input  2  extension mode (see Behaviour)
in_tag  input  TAG_W  sideband tag
flush  input  1  synchronous pipeline flush (branch mispredict / exception)
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result
out_data  output  OUT_W  extended result
out_tag  output  TAG_W  tag of the result beat

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Mode encoding:
  - 00 SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - 01 ZERO: zero upper bits.
  - 10 UPPER: in_imm placed in bits [OUT_W-1:OUT_W-IN_W], low bits 0.
  - 11 BRANCH: sign-extend, then shift left 2; the top two bits are discarded.
- Extension is computed combinationally from in_* and captured into stage 0. Stages 1..STAGES-1 only move registered beats.
- Each stage k holds valid_q[k], data_q[k], tag_q[k].
- Stage advance rule:
  - The last stage advances (is free to load) when !valid_q[last] || out_ready.
  - Stage k advances when !valid_q[k] || the next stage is free.
  - Bubbles collapse: an empty stage always loads from its predecessor.
- in_ready = !flush && stage 0 free. A transfer happens when in_valid && in_ready.
- out_valid = valid_q[last]; out_data and out_tag come from the last stage.
- Out_data and out_tag must hold stable while out_valid && !out_ready.
- Latency is exactly STAGES cycles with no stall. Throughput is 1 beat/cycle under continuous out_ready.
- Handshake rules:
  - in_valid must not depend on in_ready.
  - out_valid must not depend on out_ready combinationally.
  - in_ready may depend combinationally on out_ready; this is the full-throughput chain.
- Full pipeline with out_ready=0: in_ready=0 and no beat is lost or duplicated.
- Flush: at the next edge all valid_q clear.
  - in_ready=0 during flush, so no beat is accepted in the flush cycle.
  - A result presented with out_ready=1 in the flush cycle counts as consumed. The consumer must ignore it per core policy.
  - Data registers need not clear.
- Simultaneous flush and reset: reset wins.
- Reset (asynchronous assert, mid-operation included):
  - All valid_q=0, data_q=0, tag_q=0.
  - Hence out_valid=0, out_data=0, out_tag=0, and in_ready=1 after release (flush low).
  - In-flight beats are dropped.
- Data registers load only on advance. No enable-free shifting.

Decomposition:
- Shared package cpu_pkg holds:
  - mode localparams: EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11;
  - default IN_W=16 and OUT_W=32 constants.
- One sub-module, imm_ext_func: a purely combinational (in_imm, in_mode) -> OUT_W result, parametrised IN_W/OUT_W. It is reused by the single-cycle core path.
- imm_extend_pipe instantiates imm_ext_func plus a generate loop of STAGES pipeline registers.
- Elaboration-time check: fail if OUT_W < IN_W+2 or STAGES is outside 1..3.

Test Plan:
- Defaults, STAGES=1, out_ready=1, four beats in consecutive cycles, expect results one cycle after each input:
  - SIGN 0x8001 -> 0xFFFF8001
  - ZERO 0x8001 -> 0x00008001
  - UPPER 0x1234 -> 0x12340000
  - BRANCH 0xFFFF -> 0xFFFFFFFC
- STAGES=3, stream 10 beats (tags 0..9) with out_ready=1 -> each appears 3 cycles after its input, in order, 1/cycle.
- STAGES=2, fill the pipe and hold out_ready=0 for 5 cycles:
  - in_ready=0 after 2 accepted beats;
  - out_data/out_tag stable;
  - on release, beats drain in order with no loss or duplication.
- STAGES=3, 3 beats in flight, assert flush for 1 cycle with in_valid=1:
  - in_ready=0 that cycle;
  - next cycle out_valid=0;
  - the next accepted beat emerges 3 cycles later.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> out_valid=0, out_data=0, out_tag=0 immediately. After release, in_ready=1 and no stale beat appears.
- IN_W=8, OUT_W=16:
  - SIGN 0x80 -> 0xFF80
  - UPPER 0xA5 -> 0xA500
  - BRANCH 0x40 -> 0x0100
